// File: rtl/count_monitor_if.sv
// rtl/count_monitor_if.sv - count stream and status bundle for count_monitor
//
// Signals:
//   count, count_vld, clr           : stimulus side (driven by the master)
//   locked, err, err_cnt,
//   exp_q, act_q, stall             : status side (driven by the monitor, slave)
interface count_monitor_if #(
    parameter int WIDTH     = 32,
    parameter int ERR_CNT_W = 16
);
    logic [WIDTH-1:0]     count;
    logic                 count_vld;
    logic                 clr;
    logic                 locked;
    logic                 err;
    logic [ERR_CNT_W-1:0] err_cnt;
    logic [WIDTH-1:0]     exp_q;
    logic [WIDTH-1:0]     act_q;
    logic                 stall;

    modport master (
        output count, count_vld, clr,
        input  locked, err, err_cnt, exp_q, act_q, stall
    );

    modport slave (
        input  count, count_vld, clr,
        output locked, err, err_cnt, exp_q, act_q, stall
    );
endinterface

// File: rtl/count_monitor.sv
// rtl/count_monitor.sv - increment-by-one checker for a free-running count stream
//
// Ports:
//   i_clk : rising-edge clock
//   i_rst : synchronous reset, active-high (priority over clr and count_vld)
//   bus   : count_monitor_if.slave (count/count_vld/clr in, status out)
//
// Optional feature: define COUNT_MON_STALL_DET_EN to enable stall detection
// (stall set after STALL_LIMIT idle cycles while locked). Otherwise stall = 0.
module count_monitor #(
    parameter int WIDTH       = 32,
    parameter int LOCK_N      = 4,
    parameter int ERR_CNT_W   = 16,
    parameter int STALL_LIMIT = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,
    count_monitor_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SYNC, LOCKED} state_t;

    localparam int MCNT_W = $clog2(LOCK_N + 1);
    localparam logic [MCNT_W-1:0] LOCK_LAST = MCNT_W'(LOCK_N - 1);

    state_t               r_state;
    logic [WIDTH-1:0]     r_exp;
    logic [MCNT_W-1:0]    r_mcnt;
    logic                 r_locked;
    logic                 r_err;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic [WIDTH-1:0]     r_exp_q;
    logic [WIDTH-1:0]     r_act_q;
    logic                 r_stall;

    logic                 w_match;
    logic [WIDTH-1:0]     w_count_inc;
    logic [ERR_CNT_W-1:0] w_err_cnt_base;
    logic [ERR_CNT_W-1:0] w_err_cnt_next;

    assign w_match     = (bus.count == r_exp);
    assign w_count_inc = bus.count + WIDTH'(1);

    // A clr in the same cycle as a locked mismatch restarts the count from
    // zero, so the new error is counted as the first one.
    assign w_err_cnt_base = bus.clr ? '0 : r_err_cnt;
    assign w_err_cnt_next = (&w_err_cnt_base) ? w_err_cnt_base
                                              : w_err_cnt_base + ERR_CNT_W'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_exp     <= '0;
            r_mcnt    <= '0;
            r_locked  <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
            r_exp_q   <= '0;
            r_act_q   <= '0;
        end else begin
            if (bus.clr) begin
                r_err     <= 1'b0;
                r_err_cnt <= '0;
                r_exp_q   <= '0;
                r_act_q   <= '0;
            end
            if (bus.count_vld) begin
                case (r_state)
                    IDLE: begin
                        r_exp   <= w_count_inc;
                        r_mcnt  <= '0;
                        r_state <= SYNC;
                    end
                    SYNC: begin
                        r_exp <= w_count_inc;
                        if (w_match) begin
                            r_mcnt <= r_mcnt + MCNT_W'(1);
                            if (r_mcnt == LOCK_LAST) begin
                                r_state  <= LOCKED;
                                r_locked <= 1'b1;
                            end
                        end else begin
                            r_mcnt <= '0;
                        end
                    end
                    LOCKED: begin
                        r_exp <= w_count_inc;
                        if (!w_match) begin
                            r_err     <= 1'b1;
                            r_err_cnt <= w_err_cnt_next;
                            // Capture only the first pair since the last clear;
                            // a coincident clr makes this the first.
                            if (!r_err || bus.clr) begin
                                r_exp_q <= r_exp;
                                r_act_q <= bus.count;
                            end
                            r_mcnt   <= '0;
                            r_state  <= SYNC;
                            r_locked <= 1'b0;
                        end
                    end
                    default: begin
                        r_state  <= IDLE;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef COUNT_MON_STALL_DET_EN
    localparam int IDLE_W = $clog2(STALL_LIMIT + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(STALL_LIMIT);

    logic [IDLE_W-1:0] r_idle_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_idle_cnt <= '0;
            r_stall    <= 1'b0;
        end else begin
            if (bus.clr) begin
                r_stall <= 1'b0;
            end
            if (bus.count_vld || (r_state != LOCKED)) begin
                r_idle_cnt <= '0;
            end else if (r_idle_cnt != IDLE_MAX) begin
                r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
                // Set only on the edge the limit is reached, so a clr while
                // the counter sits at the limit leaves stall cleared.
                if (r_idle_cnt == IDLE_MAX - IDLE_W'(1)) begin
                    r_stall <= 1'b1;
                end
            end
        end
    end
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^STALL_LIMIT;
    assign r_stall      = 1'b0;
`endif

    assign bus.locked  = r_locked;
    assign bus.err     = r_err;
    assign bus.err_cnt = r_err_cnt;
    assign bus.exp_q   = r_exp_q;
    assign bus.act_q   = r_act_q;
    assign bus.stall   = r_stall;
endmodule

// File: tb/tb_count_monitor.sv
// tb/tb_count_monitor.sv - scoreboard testbench for count_monitor
module tb_count_monitor;
    localparam int WIDTH     = 32;
    localparam int ERR_CNT_W = 16;

`ifdef COUNT_MON_STALL_DET_EN
    localparam logic STALL_EXP = 1'b1;
`else
    localparam logic STALL_EXP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    count_monitor_if #(.WIDTH(WIDTH), .ERR_CNT_W(ERR_CNT_W)) bus ();

    count_monitor #(
        .WIDTH(WIDTH), .LOCK_N(4), .ERR_CNT_W(ERR_CNT_W), .STALL_LIMIT(16)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    typedef struct {
        int                   tag;
        string                name;
        logic                 locked;
        logic                 err;
        logic [ERR_CNT_W-1:0] ec;
        logic [WIDTH-1:0]     eq;
        logic [WIDTH-1:0]     aq;
        logic                 stall;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    // Monitor: after each edge, compare every expectation tagged for it.
    always @(posedge clk) begin
        exp_t e;
        #1;
        cyc++;
        while (sb.size() > 0 && sb[0].tag <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (bus.locked !== e.locked || bus.err !== e.err || bus.err_cnt !== e.ec ||
                bus.exp_q !== e.eq || bus.act_q !== e.aq || bus.stall !== e.stall) begin
                failures++;
                $display("FAIL %s: got locked=%b err=%b err_cnt=%0d exp_q=%h act_q=%h stall=%b want locked=%b err=%b err_cnt=%0d exp_q=%h act_q=%h stall=%b",
                         e.name, bus.locked, bus.err, bus.err_cnt, bus.exp_q, bus.act_q, bus.stall,
                         e.locked, e.err, e.ec, e.eq, e.aq, e.stall);
            end
        end
    end

    task automatic step(input logic v, input logic [WIDTH-1:0] c, input logic cl);
        @(negedge clk);
        bus.count     = c;
        bus.count_vld = v;
        bus.clr       = cl;
    endtask

    // Expected status after the sample driven by the most recent step.
    task automatic chk(input string name, input logic l, input logic er,
                       input logic [ERR_CNT_W-1:0] ec, input logic [WIDTH-1:0] eq,
                       input logic [WIDTH-1:0] aq, input logic st);
        exp_t e;
        e.tag = cyc + 1; e.name = name; e.locked = l; e.err = er;
        e.ec = ec; e.eq = eq; e.aq = aq; e.stall = st;
        sb.push_back(e);
    endtask

    initial begin
        bus.count = '0; bus.count_vld = 1'b0; bus.clr = 1'b0;

        repeat (10) step(1'b0, 0, 1'b0);
        chk("reset", 0, 0, 0, 0, 0, 0);

        step(1'b1, 0, 1'b0);
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, i, 1'b0);
            if (i == 3) chk("pre_lock", 0, 0, 0, 0, 0, 0);
        end
        chk("first_lock", 1, 0, 0, 0, 0, 0);

        for (int i = 5; i <= 101; i++) step(1'b1, i, 1'b0);
        chk("locked_run", 1, 0, 0, 0, 0, 0);
        step(1'b1, 150, 1'b0);
        chk("first_err", 0, 1, 1, 102, 150, 0);
        for (int i = 151; i <= 153; i++) step(1'b1, i, 1'b0);
        chk("resync_pre", 0, 1, 1, 102, 150, 0);
        step(1'b1, 154, 1'b0);
        chk("relock", 1, 1, 1, 102, 150, 0);

        step(1'b1, 32'hFFFF_FFF9, 1'b0);
        chk("second_err_hold", 0, 1, 2, 102, 150, 0);
        for (int i = 0; i < 4; i++) step(1'b1, 32'hFFFF_FFFA + i, 1'b0);
        chk("lock_high", 1, 1, 2, 102, 150, 0);
        step(1'b1, 32'hFFFF_FFFE, 1'b0);
        step(1'b1, 32'hFFFF_FFFF, 1'b0);
        step(1'b1, 32'h0000_0000, 1'b0);
        chk("wrap_zero", 1, 1, 2, 102, 150, 0);
        step(1'b1, 32'h0000_0001, 1'b0);
        chk("wrap_one", 1, 1, 2, 102, 150, 0);

        step(1'b0, 0, 1'b1);
        chk("clr", 1, 0, 0, 0, 0, 0);

        step(1'b1, 10, 1'b0);
        chk("err_a", 0, 1, 1, 2, 10, 0);
        for (int i = 11; i <= 14; i++) step(1'b1, i, 1'b0);
        step(1'b1, 20, 1'b0);
        chk("err_b", 0, 1, 2, 2, 10, 0);
        for (int i = 21; i <= 24; i++) step(1'b1, i, 1'b0);
        step(1'b1, 30, 1'b1);
        chk("clr_with_err", 0, 1, 1, 25, 30, 0);
        for (int i = 31; i <= 34; i++) step(1'b1, i, 1'b0);
        step(1'b1, 40, 1'b0);
        for (int i = 41; i <= 44; i++) step(1'b1, i, 1'b0);
        step(1'b1, 50, 1'b0);
        chk("err_cnt3", 0, 1, 3, 25, 30, 0);

        step(1'b1, 51, 1'b1);
        rst = 1'b1;
        chk("mid_reset", 0, 0, 0, 0, 0, 0);
        step(1'b1, 7, 1'b0);
        rst = 1'b0;
        step(1'b1, 8, 1'b0);
        step(1'b0, 99, 1'b0);
        chk("vld_low_hold", 0, 0, 0, 0, 0, 0);
        step(1'b1, 9, 1'b0);
        step(1'b1, 10, 1'b0);
        chk("relock_pre", 0, 0, 0, 0, 0, 0);
        step(1'b1, 11, 1'b0);
        chk("relock_after_rst", 1, 0, 0, 0, 0, 0);

        repeat (15) step(1'b0, 0, 1'b0);
        chk("idle15", 1, 0, 0, 0, 0, 0);
        step(1'b0, 0, 1'b0);
        chk("idle16", 1, 0, 0, 0, 0, STALL_EXP);
        step(1'b1, 12, 1'b0);
        chk("stall_sticky", 1, 0, 0, 0, 0, STALL_EXP);
        step(1'b0, 0, 1'b1);
        chk("stall_clr", 1, 0, 0, 0, 0, 0);

        repeat (3) step(1'b0, 0, 1'b0);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/count_monitor.md
# count_monitor

Receive-side checker for the free-running counter: samples a WIDTH-bit count stream once per valid cycle and verifies it increments by exactly one. It locks after a run of consecutive good samples and records sticky error status, a saturating error count and the first offending sample pair. It sits beside the counter in the same clock domain and feeds status to test benches and debug registers.

## Interface
- WIDTH, 32, width of the monitored count
- LOCK_N, 4, consecutive correct increments required to declare lock (≥1)
- ERR_CNT_W, 16, width of the error counter
- STALL_LIMIT, 16, idle cycles while locked before a stall is flagged (used only with the macro)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- count  in  WIDTH  observed counter value
- count_vld  in  1  count is valid this cycle
- clr  in  1  one-cycle pulse: clear err, err_cnt, exp_q, act_q, stall
- locked  out  1  stream is tracking with LOCK_N good increments
- err  out  1  sticky: a mismatch occurred while locked
- err_cnt  out  ERR_CNT_W  mismatches while locked, saturates at all-ones
- exp_q  out  WIDTH  expected value at first error since last clear
- act_q  out  WIDTH  actual value at first error since last clear
- stall  out  1  sticky stall flag (0 when macro absent)

## Operation
- Internal: expected register exp (WIDTH), match counter mcnt (0..LOCK_N), state.
- States: IDLE, SYNC, LOCKED.
- IDLE: first count_vld loads exp = count+1, mcnt = 0, goes to SYNC.
- SYNC, count_vld and count == exp: mcnt++, exp = count+1. Once mcnt reaches LOCK_N, go to LOCKED.
- SYNC, count_vld and count != exp: exp = count+1, mcnt = 0, stay in SYNC. No error is recorded.
- LOCKED, match: exp = count+1.
- LOCKED, mismatch:
  - err = 1, err_cnt increments (saturating).
  - If err was 0, capture exp_q = exp and act_q = count.
  - exp = count+1, mcnt = 0, go to SYNC (resync).
- count_vld low: no check. exp, mcnt and state hold.
- Arithmetic is modulo 2^WIDTH: all-ones followed by zero is a match.
- clr: clears err, err_cnt, exp_q, act_q and stall. It does not affect state, exp, mcnt or locked.
- clr coinciding with a LOCKED mismatch: the new error wins. Result is err=1, err_cnt=1, and exp_q/act_q hold the new pair.
- err_cnt at all-ones and a further mismatch: err_cnt holds. Resync still occurs.

## Timing
- All outputs are registered. A sample at edge N is reflected in outputs after edge N, i.e. visible in cycle N+1.
- locked rises in the cycle after the LOCK_N-th consecutive match. It falls in the cycle after a mismatch.
- Minimum lock time from reset release: LOCK_N+1 valid samples.
- rst (synchronous) forces:
  - state = IDLE
  - locked, err, stall = 0
  - err_cnt, exp_q, act_q, exp, mcnt = 0
- Reset asserted mid-operation behaves identically to power-on reset; no status survives.
- rst has priority over clr and count_vld.

## Configuration
- COUNT_MON_STALL_DET_EN defined: an idle counter, cleared on count_vld or when not LOCKED, counts cycles with count_vld low while LOCKED.
  - When it reaches STALL_LIMIT, stall is set (sticky until clr or rst) and the counter holds.
  - Setting stall does not change state.
- COUNT_MON_STALL_DET_EN undefined: no idle counter exists and stall is tied to 0.

## Test plan
- Reset for 10 cycles, then count = 0,1,2,… with count_vld=1 → locked=1 in the cycle after the 5th sample (LOCK_N=4); err=0, err_cnt=0.
- Once locked, drive count 100,101,150,151 → err=1, err_cnt=1, exp_q=102, act_q=150. locked drops, then re-rises after 4 more matches.
- Drive count FFFF_FFFE, FFFF_FFFF, 0, 1 while locked → no error (wrap-around accepted).
- Two errors while locked, then clr pulse coinciding with a third error → err=1, err_cnt=1, exp_q/act_q hold the third pair.
- Assert rst mid-stream while err=1 and err_cnt=3 → all outputs 0 next cycle, state IDLE; relock proceeds normally.
- With COUNT_MON_STALL_DET_EN, while locked hold count_vld=0 for 16 cycles → stall=1 and locked stays 1. With 15 idle cycles → stall stays 0. Without the macro, stall=0 always.
